// File: rtl/hdu_idex.sv
// ID/EX pipeline register for the 5-stage RV32I core with load-use hazard
// detection, bubble insertion, flush/hold handling and a saturating stall counter.
module hdu_idex #(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int ALUOP_WIDTH   = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ifidValid,
  input  logic [RF_ADDR_WIDTH-1:0] ifidRs1,
  input  logic [RF_ADDR_WIDTH-1:0] ifidRs2,
  input  logic [RF_ADDR_WIDTH-1:0] ifidRd,
  input  logic                     ifidUsesRs1,
  input  logic                     ifidUsesRs2,
  input  logic                     idRegWrite,
  input  logic                     idMemRead,
  input  logic                     idMemWrite,
  input  logic                     idMemToReg,
  input  logic                     idAluSrc,
  input  logic [ALUOP_WIDTH-1:0]   idAluOp,
  input  logic [XLEN-1:0]          idPc,
  input  logic [XLEN-1:0]          idImm,
  input  logic [XLEN-1:0]          idRs1Data,
  input  logic [XLEN-1:0]          idRs2Data,
  input  logic                     flush,
  input  logic                     exHold,
  output logic                     pcWrite,
  output logic                     ifidWrite,
  output logic                     loadUseStall,
  output logic                     idexValid,
  output logic                     idexRegWrite,
  output logic                     idexMemRead,
  output logic                     idexMemWrite,
  output logic                     idexMemToReg,
  output logic                     idexAluSrc,
  output logic [ALUOP_WIDTH-1:0]   idexAluOp,
  output logic [RF_ADDR_WIDTH-1:0] idexRs1,
  output logic [RF_ADDR_WIDTH-1:0] idexRs2,
  output logic [RF_ADDR_WIDTH-1:0] idexRd,
  output logic [XLEN-1:0]          idexPc,
  output logic [XLEN-1:0]          idexImm,
  output logic [XLEN-1:0]          idexRs1Data,
  output logic [XLEN-1:0]          idexRs2Data,
  output logic [CNT_WIDTH-1:0]     stallCount
);

  logic rs1Match;
  logic rs2Match;
  logic insertBubble;

  // A load whose destination is read by the instruction in ID; x0 never stalls.
  assign rs1Match     = ifidUsesRs1 && (ifidRs1 == idexRd);
  assign rs2Match     = ifidUsesRs2 && (ifidRs2 == idexRd);
  assign loadUseStall = idexValid && idexMemRead && (idexRd != '0) && ifidValid
                        && (rs1Match || rs2Match);

  assign pcWrite      = !exHold && !loadUseStall;
  assign ifidWrite    = !exHold && !loadUseStall;
  assign insertBubble = flush || loadUseStall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idexValid    <= 1'b0;
      idexRegWrite <= 1'b0;
      idexMemRead  <= 1'b0;
      idexMemWrite <= 1'b0;
      idexMemToReg <= 1'b0;
      idexAluSrc   <= 1'b0;
      idexAluOp    <= '0;
      idexRs1      <= '0;
      idexRs2      <= '0;
      idexRd       <= '0;
      idexPc       <= '0;
      idexImm      <= '0;
      idexRs1Data  <= '0;
      idexRs2Data  <= '0;
    end else if (exHold) begin
      // Frozen: every field keeps its value, flush included.
    end else if (insertBubble) begin
      idexValid    <= 1'b0;
      idexRegWrite <= 1'b0;
      idexMemRead  <= 1'b0;
      idexMemWrite <= 1'b0;
      idexMemToReg <= 1'b0;
      idexAluSrc   <= 1'b0;
      idexAluOp    <= '0;
      idexRs1      <= '0;
      idexRs2      <= '0;
      idexRd       <= '0;
      idexPc       <= '0;
      idexImm      <= '0;
      idexRs1Data  <= '0;
      idexRs2Data  <= '0;
    end else begin
      // An invalid ID slot is captured as a bubble: its control bits are masked.
      idexValid    <= ifidValid;
      idexRegWrite <= ifidValid && idRegWrite;
      idexMemRead  <= ifidValid && idMemRead;
      idexMemWrite <= ifidValid && idMemWrite;
      idexMemToReg <= ifidValid && idMemToReg;
      idexAluSrc   <= ifidValid && idAluSrc;
      idexAluOp    <= ifidValid ? idAluOp : '0;
      idexRs1      <= ifidRs1;
      idexRs2      <= ifidRs2;
      idexRd       <= ifidRd;
      idexPc       <= idPc;
      idexImm      <= idImm;
      idexRs1Data  <= idRs1Data;
      idexRs2Data  <= idRs2Data;
    end
  end

  // Counts only bubbles caused by the hazard itself, never flush or hold cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCount <= '0;
    end else if (!exHold && !flush && loadUseStall && (stallCount != '1)) begin
      stallCount <= stallCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hdu_idex.sv
// Self-checking bench for hdu_idex: directed scenarios plus random stimulus
// compared against an instruction-level reference model.
module tb_hdu_idex;
  localparam int XLEN = 32;
  localparam int RFA  = 5;
  localparam int AOW  = 4;
  // Narrow counter so saturation is reachable in a few hundred cycles.
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic            valid;
    logic [RFA-1:0]  rs1, rs2, rd;
    logic            usesRs1, usesRs2;
    logic            regWrite, memRead, memWrite, memToReg, aluSrc;
    logic [AOW-1:0]  aluOp;
    logic [XLEN-1:0] pc, imm, d1, d2;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, exHold;
  instr_t id;

  logic pcWrite, ifidWrite, loadUseStall;
  logic idexValid, idexRegWrite, idexMemRead, idexMemWrite, idexMemToReg, idexAluSrc;
  logic [AOW-1:0]  idexAluOp;
  logic [RFA-1:0]  idexRs1, idexRs2, idexRd;
  logic [XLEN-1:0] idexPc, idexImm, idexRs1Data, idexRs2Data;
  logic [CW-1:0]   stallCount;

  hdu_idex #(.XLEN(XLEN), .RF_ADDR_WIDTH(RFA), .ALUOP_WIDTH(AOW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifidValid(id.valid), .ifidRs1(id.rs1), .ifidRs2(id.rs2), .ifidRd(id.rd),
    .ifidUsesRs1(id.usesRs1), .ifidUsesRs2(id.usesRs2),
    .idRegWrite(id.regWrite), .idMemRead(id.memRead), .idMemWrite(id.memWrite),
    .idMemToReg(id.memToReg), .idAluSrc(id.aluSrc), .idAluOp(id.aluOp),
    .idPc(id.pc), .idImm(id.imm), .idRs1Data(id.d1), .idRs2Data(id.d2),
    .flush(flush), .exHold(exHold),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .loadUseStall(loadUseStall),
    .idexValid(idexValid), .idexRegWrite(idexRegWrite), .idexMemRead(idexMemRead),
    .idexMemWrite(idexMemWrite), .idexMemToReg(idexMemToReg), .idexAluSrc(idexAluSrc),
    .idexAluOp(idexAluOp), .idexRs1(idexRs1), .idexRs2(idexRs2), .idexRd(idexRd),
    .idexPc(idexPc), .idexImm(idexImm), .idexRs1Data(idexRs1Data),
    .idexRs2Data(idexRs2Data), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction sitting in EX and the stall tally.
  instr_t ex;
  int     modelCount;
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic modelHazard();
    logic dep;
    dep = (id.usesRs1 && id.rs1 == ex.rd) || (id.usesRs2 && id.rs2 == ex.rd);
    return ex.valid && ex.memRead && (ex.rd != 0) && id.valid && dep;
  endfunction

  function automatic instr_t mk(input logic v, input int rs1, input int rs2, input int rd,
                                input logic u1, input logic u2, input logic rw,
                                input logic mr, input int pc);
    instr_t t;
    t = '0;
    t.valid = v; t.rs1 = RFA'(rs1); t.rs2 = RFA'(rs2); t.rd = RFA'(rd);
    t.usesRs1 = u1; t.usesRs2 = u2; t.regWrite = rw; t.memRead = mr; t.memToReg = mr;
    t.aluSrc = mr; t.aluOp = 4'h2; t.pc = XLEN'(pc); t.imm = XLEN'(pc * 3);
    t.d1 = $urandom; t.d2 = $urandom;
    return t;
  endfunction

  function automatic instr_t randInstr();
    instr_t t;
    t = '0;
    t.valid = ($urandom_range(0, 7) != 0);
    t.rs1 = RFA'($urandom_range(0, 7)); t.rs2 = RFA'($urandom_range(0, 7));
    t.rd  = RFA'($urandom_range(0, 7));
    t.usesRs1 = $urandom_range(0, 1) == 1; t.usesRs2 = $urandom_range(0, 1) == 1;
    t.regWrite = $urandom_range(0, 1) == 1; t.memRead = $urandom_range(0, 1) == 1;
    t.memWrite = $urandom_range(0, 1) == 1; t.memToReg = $urandom_range(0, 1) == 1;
    t.aluSrc = $urandom_range(0, 1) == 1; t.aluOp = AOW'($urandom);
    t.pc = $urandom; t.imm = $urandom; t.d1 = $urandom; t.d2 = $urandom;
    return t;
  endfunction

  // Inputs are set after a falling edge; one tick checks the hazard outputs,
  // advances the model over the rising edge and checks the register contents.
  task automatic tick(input bit checkComb = 1'b1);
    logic hz;
    #1;
    hz = modelHazard();
    if (checkComb) begin
      check("loadUseStall", loadUseStall, hz);
      check("pcWrite", pcWrite, !exHold && !hz);
      check("ifidWrite", ifidWrite, !exHold && !hz);
    end
    if (flush && exHold) $display("note: flush and exHold both high at %0t", $time);
    @(posedge clk);
    if (!rst_n) begin
      ex = '0;
      modelCount = 0;
    end else if (exHold) begin
      // instruction stays in EX
    end else if (flush || hz) begin
      ex = '0;
      if (!flush && modelCount < CMAX) modelCount++;
    end else begin
      ex = id;
      if (!id.valid) begin
        ex.regWrite = 0; ex.memRead = 0; ex.memWrite = 0; ex.memToReg = 0;
        ex.aluSrc = 0; ex.aluOp = '0;
      end
    end
    @(negedge clk);
    check("idexValid", idexValid, ex.valid);
    check("idexCtl", {idexRegWrite, idexMemRead, idexMemWrite, idexMemToReg, idexAluSrc},
          {ex.regWrite, ex.memRead, ex.memWrite, ex.memToReg, ex.aluSrc});
    check("idexAluOp", idexAluOp, ex.aluOp);
    check("idexRegs", {idexRs1, idexRs2, idexRd}, {ex.rs1, ex.rs2, ex.rd});
    check("idexPc", idexPc, ex.pc);
    check("idexImm", idexImm, ex.imm);
    check("idexData", {idexRs1Data, idexRs2Data}, {ex.d1, ex.d2});
    check("stallCount", stallCount, modelCount);
  endtask

  initial begin
    logic [XLEN-1:0] heldPc;
    logic [CW-1:0]   savedCount;
    ex = '0; modelCount = 0;
    rst_n = 1'b0; flush = 1'b0; exHold = 1'b0;
    id = randInstr();

    // Reset with random inputs for two cycles.
    @(negedge clk);
    tick(1'b0);
    id = randInstr();
    tick(1'b1);
    check("resetValid", idexValid, 1'b0);
    check("resetCount", stallCount, '0);
    rst_n = 1'b1;
    id = mk(1, 1, 2, 3, 1, 1, 1, 0, 'h100);
    #1;
    check("pcWriteAfterReset", pcWrite, 1'b1);
    check("ifidWriteAfterReset", ifidWrite, 1'b1);

    // Plain capture: add x3,x1,x2.
    tick();
    check("addRd", idexRd, 5'd3);
    check("addRegWrite", idexRegWrite, 1'b1);
    check("addPc", idexPc, 32'h100);
    check("addValid", idexValid, 1'b1);

    // Load-use: lw x5 followed by add x6,x5,x7.
    id = mk(1, 1, 0, 5, 1, 0, 1, 1, 'h104);
    tick();
    id = mk(1, 5, 7, 6, 1, 1, 1, 0, 'h108);
    #1;
    check("luStall", loadUseStall, 1'b1);
    check("luPcWrite", pcWrite, 1'b0);
    check("luIfidWrite", ifidWrite, 1'b0);
    tick();
    check("luBubbleValid", idexValid, 1'b0);
    check("luCount", stallCount, CW'(1));
    tick();
    check("luAddRs1", idexRs1, 5'd5);
    check("luAddValid", idexValid, 1'b1);

    // lw x0 then a reader of x0: no stall.
    id = mk(1, 1, 0, 0, 1, 0, 1, 1, 'h10c);
    tick();
    id = mk(1, 0, 0, 9, 1, 1, 1, 0, 'h110);
    #1;
    check("x0NoStall", loadUseStall, 1'b0);
    tick();

    // lw x5 then addi x6,x8,imm whose unused rs2 field is 5: no stall.
    id = mk(1, 1, 0, 5, 1, 0, 1, 1, 'h114);
    tick();
    id = mk(1, 8, 5, 6, 1, 0, 1, 0, 'h118);
    #1;
    check("unusedRs2NoStall", loadUseStall, 1'b0);
    tick();

    // Flush coinciding with a hazard: one bubble, counter unchanged.
    id = mk(1, 1, 0, 5, 1, 0, 1, 1, 'h11c);
    tick();
    savedCount = stallCount;
    id = mk(1, 5, 0, 6, 1, 0, 1, 0, 'h120);
    flush = 1'b1;
    tick();
    check("flushHzValid", idexValid, 1'b0);
    check("flushHzCount", stallCount, savedCount);
    // Flush alone.
    id = mk(1, 2, 3, 4, 1, 1, 1, 0, 'h124);
    tick();
    check("flushValid", idexValid, 1'b0);
    check("flushRegWrite", idexRegWrite, 1'b0);
    flush = 1'b0;

    // exHold for three cycles with changing ID and a flush pulse.
    id = mk(1, 2, 3, 4, 1, 1, 1, 0, 'h200);
    tick();
    heldPc = idexPc;
    exHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = randInstr();
      flush = (i == 1);
      #1;
      check("holdPcWrite", pcWrite, 1'b0);
      tick();
      check("holdPc", idexPc, heldPc);
    end
    exHold = 1'b0; flush = 1'b0;
    id = mk(1, 4, 0, 7, 1, 0, 1, 0, 'h300);
    tick();
    check("releasePc", idexPc, 32'h300);

    // Reset in the middle of a stall.
    id = mk(1, 5, 0, 5, 1, 0, 1, 1, 'h400);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    id = mk(1, 5, 0, 6, 1, 0, 1, 0, 'h404);
    tick();
    check("postResetCapturePc", idexPc, 32'h404);

    // Saturation: lw x5,0(x5) repeated stalls every other cycle.
    id = mk(1, 5, 0, 5, 1, 0, 1, 1, 'h500);
    for (int i = 0; i < 2 * CMAX + 8; i++) tick();
    check("saturated", stallCount, CMAX);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      id = randInstr();
      rst_n = ($urandom_range(0, 63) != 0);
      exHold = ($urandom_range(0, 7) == 0);
      flush = !exHold && ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_n = 1'b1; exHold = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
